uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  Serialising UART transmitter; the transmit partner of the correlator's uart_rx.
//  Sends one line bit per clk cycle, so clk is the bit clock and there is no baud divider.
//  Frame: start(0), tx_bits data bits LSB first, [parity], stop(1); the line idles high.
//  A one-entry hold buffer lets the host queue the next word during a frame, so frames run back to back.
// PARAMETERS
//  MAX_WORD_SIZE  8  width of din and the largest legal word length
// PORTS
//  clk       in   1              bit clock; the only clock domain
//  rst       in   1              synchronous, active-high reset
//  din       in   MAX_WORD_SIZE  word to send; bits above tx_bits-1 are ignored
//  tx_bits   in   6              word length, sampled with din on accept
//  tx_start  in   1              request to send din; accepted when tx_ready=1
//  tx_ready  out  1              hold buffer empty; a tx_start is accepted this cycle
//  tx        out  1              serial line, registered
//  tx_busy   out  1              a frame is on the line (start through stop)
//  tx_done   out  1              one-cycle pulse in the cycle after the stop bit
// BEHAVIOUR
//  Reset: tx=1, tx_ready=1, tx_busy=0, tx_done=0, hold empty, state IDLE, counters 0.
//  Accept: tx_start&&tx_ready in cycle k stores {din, tx_bits} in hold and drops tx_ready at k+1.
//  Length clamp: tx_bits==0 or tx_bits>MAX_WORD_SIZE is stored as MAX_WORD_SIZE.
//  FSM states (all transitions on posedge clk):
//   IDLE: tx=1. If hold is full, load shifter and counter from hold, free hold, go to START.
//   START: tx=0 for one cycle; go to DATA with bit_count=0.
//   DATA: tx=shift[0], shift right, bit_count++; on bit_count==len-1 go to PARITY (if enabled) else STOP.
//   PARITY: tx=parity for one cycle; go to STOP.
//   STOP: tx=1 for one cycle. If hold is full, go straight to START (no idle gap); otherwise go to IDLE.
//  Latency: a word accepted at cycle k with the FSM idle drives tx=0 at k+2.
//   The first data bit appears at k+3.
//  Frame length: len+2 cycles, or len+3 with parity. This matches uart_rx timing: its STOP state
//   lands on our stop bit, and its IDLE state samples the next start bit.
//  tx_busy=1 while the state is START, DATA, PARITY or STOP.
//  tx_done=1 for exactly one cycle after each STOP, including back-to-back frames.
//  Hold is freed the cycle the shifter loads, so tx_ready rises during START of that frame.
//  Simultaneous accept and load: the hold register cannot be written and read in one cycle.
//   Accept needs hold empty; load needs hold full.
//  tx_start while tx_ready=0 is ignored; no error flag is raised.
//  rst mid-frame: the frame is aborted and the hold word discarded.
//   tx returns to 1 the next cycle; a truncated frame is allowed.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state present; even parity bit = XOR of the len data bits.
//   The receiver must then be configured for len+1 bits.
//  UART_TX_PARITY_EN undefined: PARITY state and its logic are removed; DATA goes straight to STOP.
// STRUCTURE
//  Shared package uart_pkg holds:
//   state encodings (IDLE/START/DATA/PARITY/STOP, 3 bits)
//   the 6-bit BITS_W width for tx_bits/rx_bits
//   the IDLE_LEVEL=1 and START_LEVEL=0 line constants
//  uart_rx uses the same package for its encodings.
//  Sub-module uart_tx_hold: one-entry buffer (valid flag plus {din, len} register) with push/pop.
//   It drives tx_ready.
//  The FSM, shifter and counter stay in uart_tx.
// TESTING
//  Loop back through uart_rx with rx_bits=tx_bits; check dout and rx_done against sent words.
//  1. Reset, then din=8'hA5, tx_bits=8, tx_start 1 cycle:
//     tx=1,0,1,0,1,0,0,1,0,1,1 from k+1; one tx_done; rx dout=8'hA5.
//  2. Two words 8'h3C and 8'hC3 queued back to back:
//     second start bit directly follows the first stop bit; 2 tx_done pulses; both received in order.
//  3. tx_bits=5, din=8'hFF: exactly 5 data ones then stop; frame is 7 cycles; dout=8'h1F.
//  4. tx_bits=0 and tx_bits=9: each sends 8 bits (clamped); tx_start while tx_ready=0 is dropped.
//  5. rst asserted during data bit 3, with a second word in hold:
//     tx=1 the next cycle; no tx_done; tx_ready=1; no further frames.
//  6. UART_TX_PARITY_EN, din=8'h07, tx_bits=8: parity bit=1 between data and stop; frame is 11 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_tx and uart_rx: FSM state encodings,
// the word-length field width and the line levels.
package uart_pkg;

    localparam int   BITS_W      = 6;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // A zero or oversized word length means "use the full word".
    function automatic logic [BITS_W-1:0] clamp_len(input logic [BITS_W-1:0] bits,
                                                    input logic [BITS_W-1:0] max_len);
        if (bits == '0 || bits > max_len) begin
            return max_len;
        end
        return bits;
    endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry hold buffer for uart_tx: stores {word, clamped length} so the host
// can queue the next word while a frame is on the line.
module uart_tx_hold
    import uart_pkg::*;
#(
    parameter int MAX_WORD_SIZE = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [MAX_WORD_SIZE-1:0] i_data,
    input  logic [BITS_W-1:0]        i_bits,
    output logic                     o_ready,
    output logic                     o_valid,
    output logic [MAX_WORD_SIZE-1:0] o_data,
    output logic [BITS_W-1:0]        o_len
);

    localparam logic [BITS_W-1:0] MAX_LEN = BITS_W'(MAX_WORD_SIZE);

    logic                     r_valid;
    logic [MAX_WORD_SIZE-1:0] r_data;
    logic [BITS_W-1:0]        r_len;

    // Push only lands when empty and pop only when full, so the two never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_len   <= '0;
        end else if (i_push && !r_valid) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_len   <= clamp_len(i_bits, MAX_LEN);
        end else if (i_pop && r_valid) begin
            r_valid <= 1'b0;
        end
    end

    assign o_ready = !r_valid;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_len   = r_len;

endmodule

// File: rtl/uart_tx.sv
// Serialising UART transmitter, one line bit per clk: start, LSB-first data,
// optional even parity (define UART_TX_PARITY_EN), stop; back-to-back via hold buffer.
module uart_tx
    import uart_pkg::*;
#(
    parameter int MAX_WORD_SIZE = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [MAX_WORD_SIZE-1:0] din,
    input  logic [BITS_W-1:0]        tx_bits,
    input  logic                     tx_start,
    output logic                     tx_ready,
    output logic                     tx,
    output logic                     tx_busy,
    output logic                     tx_done
);

    logic                     w_hold_valid;
    logic [MAX_WORD_SIZE-1:0] w_hold_data;
    logic [BITS_W-1:0]        w_hold_len;
    logic                     w_load;

    uart_state_t              r_state;
    logic [MAX_WORD_SIZE-1:0] r_shift;
    logic [BITS_W-1:0]        r_count;
    logic [BITS_W-1:0]        r_len;
    logic                     r_tx;
    logic                     r_busy;
    logic                     r_done;

    uart_tx_hold #(
        .MAX_WORD_SIZE(MAX_WORD_SIZE)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .i_push  (tx_start),
        .i_pop   (w_load),
        .i_data  (din),
        .i_bits  (tx_bits),
        .o_ready (tx_ready),
        .o_valid (w_hold_valid),
        .o_data  (w_hold_data),
        .o_len   (w_hold_len)
    );

    // A new frame starts from IDLE or directly out of STOP, giving no idle gap.
    assign w_load = w_hold_valid && (r_state == ST_IDLE || r_state == ST_STOP);

`ifdef UART_TX_PARITY_EN
    logic [MAX_WORD_SIZE-1:0] w_mask;
    logic                     w_parity;
    logic                     r_parity;

    for (genvar gi = 0; gi < MAX_WORD_SIZE; gi++) begin : g_mask
        assign w_mask[gi] = (BITS_W'(gi) < w_hold_len);
    end

    assign w_parity = ^(w_hold_data & w_mask);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_count <= '0;
            r_len   <= '0;
            r_tx    <= IDLE_LEVEL;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tx   <= IDLE_LEVEL;
                    r_busy <= 1'b0;
                end
                ST_START: begin
                    r_state <= ST_DATA;
                    r_tx    <= r_shift[0];
                    r_shift <= r_shift >> 1;
                    r_count <= '0;
                end
                ST_DATA: begin
                    if (r_count == r_len - BITS_W'(1)) begin
`ifdef UART_TX_PARITY_EN
                        r_state <= ST_PARITY;
                        r_tx    <= r_parity;
`else
                        r_state <= ST_STOP;
                        r_tx    <= IDLE_LEVEL;
`endif
                    end else begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_count <= r_count + BITS_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    r_state <= ST_STOP;
                    r_tx    <= IDLE_LEVEL;
                end
`endif
                ST_STOP: begin
                    r_state <= ST_IDLE;
                    r_tx    <= IDLE_LEVEL;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= IDLE_LEVEL;
                    r_busy  <= 1'b0;
                end
            endcase

            // Loading overrides the IDLE/STOP defaults above.
            if (w_load) begin
                r_state <= ST_START;
                r_shift <= w_hold_data;
                r_len   <= w_hold_len;
                r_count <= '0;
                r_tx    <= START_LEVEL;
                r_busy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
                r_parity <= w_parity;
`endif
            end
        end
    end

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-queue reference model compared every cycle,
// an in-bench line receiver, and directed vectors with hand-computed line patterns.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int W = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  din;
    logic [BITS_W-1:0] tx_bits;
    logic          tx_start;
    logic          tx_ready;
    logic          tx;
    logic          tx_busy;
    logic          tx_done;

    always #5 clk = ~clk;

    uart_tx #(.MAX_WORD_SIZE(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .tx_bits  (tx_bits),
        .tx_start (tx_start),
        .tx_ready (tx_ready),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: whole frames as bit queues ----------------
    typedef bit bitq_t[$];
    typedef struct {
        logic [W-1:0] data;
        int           len;
    } word_t;

    function automatic int eff_len(input logic [BITS_W-1:0] b);
        if (b == 0 || int'(b) > W) return W;
        return int'(b);
    endfunction

    function automatic bitq_t make_frame(input logic [W-1:0] d, input logic [BITS_W-1:0] b);
        bitq_t f;
        int n = eff_len(b);
        f.push_back(1'b0);
        for (int i = 0; i < n; i++) f.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        begin
            bit p = 1'b0;
            for (int i = 0; i < n; i++) p ^= d[i];
            f.push_back(p);
        end
`endif
        f.push_back(1'b1);
        return f;
    endfunction

    bitq_t m_q;          // bits still to appear on the line; m_q[0] is the current one
    bitq_t m_hold_f;
    bit    m_hold_v = 1'b0;
    bit    m_done   = 1'b0;
    bit    m_valid  = 1'b0;
    word_t sent_q[$];

    always @(posedge clk) begin
        bit    pre_hold;
        int    pre_sz;
        word_t w;
        if (rst) begin
            m_q.delete();
            m_hold_v = 1'b0;
            m_done   = 1'b0;
            sent_q.delete();
            m_valid  = 1'b1;
        end else if (m_valid) begin
            pre_hold = m_hold_v;
            pre_sz   = m_q.size();
            m_done   = (pre_sz == 1);
            if (pre_sz > 0) void'(m_q.pop_front());
            if (pre_hold && pre_sz <= 1) begin
                m_q      = m_hold_f;
                m_hold_v = 1'b0;
            end
            if (tx_start && !pre_hold) begin
                m_hold_f = make_frame(din, tx_bits);
                m_hold_v = 1'b1;
                w.len  = eff_len(tx_bits);
                w.data = '0;
                for (int i = 0; i < w.len; i++) w.data[i] = din[i];
                sent_q.push_back(w);
            end
        end
    end

    // ---------------- per-cycle compare, line log and receiver ----------------
    bit           line_log[$];
    int           done_cnt = 0;
    int           busy_cnt = 0;
    logic [W-1:0] rx_words[$];
    bit           rx_active = 1'b0;
    int           rx_cnt = 0;
    int           rx_len = 0;
    bit           rx_par_pending = 1'b0;
    logic [W-1:0] rx_word = '0;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("tx",       tx,       (m_q.size() > 0) ? m_q[0] : 1'b1);
            chk("tx_ready", tx_ready, !m_hold_v);
            chk("tx_busy",  tx_busy,  m_q.size() > 0);
            chk("tx_done",  tx_done,  m_done);
            line_log.push_back(tx);
            if (tx_done === 1'b1) done_cnt++;
            if (tx_busy === 1'b1) busy_cnt++;

            if (rst) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (tx === 1'b0) begin
                    if (sent_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rx_start: start bit seen with no word outstanding");
                    end else begin
                        rx_active      = 1'b1;
                        rx_cnt         = 0;
                        rx_len         = sent_q[0].len;
                        rx_word        = '0;
                        rx_par_pending = (PB != 0);
                    end
                end
            end else if (rx_cnt < rx_len) begin
                rx_word[rx_cnt] = tx;
                rx_cnt++;
            end else if (rx_par_pending) begin
                chk("rx_parity", tx, ^rx_word);
                rx_par_pending = 1'b0;
            end else begin
                chk("rx_stop", tx, 1'b1);
                chk("rx_word", rx_word, sent_q[0].data);
                void'(sent_q.pop_front());
                rx_words.push_back(rx_word);
                rx_active = 1'b0;
            end
        end
    end

    function automatic logic [31:0] pack(input int idx, input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[30:0], line_log[idx + i]};
        return v;
    endfunction

    function automatic logic [31:0] rx_at(input int back);
        if (rx_words.size() > back) return 32'(rx_words[rx_words.size() - 1 - back]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic next();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic [BITS_W-1:0] b);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 50) begin
            next();
            n++;
        end
        if (tx_ready !== 1'b1) chk("send_ready_timeout", tx_ready, 1'b1);
        din      = d;
        tx_bits  = b;
        tx_start = 1'b1;
        next();
        tx_start = 1'b0;
    endtask

    initial begin
        repeat (3000) @(posedge clk);
        $display("FAIL watchdog: no finish after 3000 cycles (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, d0, b0, r0;
        rst      = 1'b1;
        tx_start = 1'b0;
        din      = '0;
        tx_bits  = '0;
        repeat (2) next();
        rst = 1'b0;
        next();
        chk("reset_tx",    tx,       1'b1);
        chk("reset_ready", tx_ready, 1'b1);
        chk("reset_busy",  tx_busy,  1'b0);
        chk("reset_done",  tx_done,  1'b0);

        // 1: single 8-bit word
        idx = line_log.size(); d0 = done_cnt; r0 = rx_words.size();
        send(8'hA5, 6'd8);
        repeat (13) next();
`ifndef UART_TX_PARITY_EN
        chk("t1_line", pack(idx, 11), 32'b10101001011);
`endif
        chk("t1_done_pulses", done_cnt - d0, 1);
        chk("t1_rx_count", rx_words.size() - r0, 1);
        chk("t1_rx_word", rx_at(0), 8'hA5);
        $display("t1 word A5 len 8: rx=%0h done=%0d", rx_at(0), done_cnt - d0);

        // 2: back-to-back frames
        idx = line_log.size(); d0 = done_cnt; r0 = rx_words.size();
        send(8'h3C, 6'd8);
        send(8'hC3, 6'd8);
        repeat (22) next();
`ifndef UART_TX_PARITY_EN
        chk("t2_line", pack(idx, 21), 32'b1_0001111001_0110000111);
`endif
        chk("t2_done_pulses", done_cnt - d0, 2);
        chk("t2_rx_count", rx_words.size() - r0, 2);
        chk("t2_rx_first", rx_at(1), 8'h3C);
        chk("t2_rx_second", rx_at(0), 8'hC3);
        $display("t2 words 3C,C3 back to back: rx=%0h,%0h done=%0d", rx_at(1), rx_at(0), done_cnt - d0);

        // 3: short word, upper din bits ignored
        idx = line_log.size(); b0 = busy_cnt;
        send(8'hFF, 6'd5);
        repeat (10) next();
`ifndef UART_TX_PARITY_EN
        chk("t3_line", pack(idx, 9), 32'b101111111);
`endif
        chk("t3_frame_cycles", busy_cnt - b0, 7 + PB);
        chk("t3_rx_word", rx_at(0), 8'h1F);
        $display("t3 word FF len 5: rx=%0h busy cycles=%0d", rx_at(0), busy_cnt - b0);

        // 4: clamped lengths and a dropped request while not ready
        d0 = done_cnt; r0 = rx_words.size();
        send(8'h81, 6'd0);
        din = 8'hFF; tx_bits = 6'd3; tx_start = 1'b1;
        next();
        tx_start = 1'b0;
        send(8'h5A, 6'd9);
        repeat (25) next();
        chk("t4_done_pulses", done_cnt - d0, 2);
        chk("t4_rx_count", rx_words.size() - r0, 2);
        chk("t4_rx_len0", rx_at(1), 8'h81);
        chk("t4_rx_len9", rx_at(0), 8'h5A);
        $display("t4 words 81(len0),5A(len9): rx=%0h,%0h", rx_at(1), rx_at(0));

        // 5: reset during data bit 3 with a word waiting in hold
        d0 = done_cnt; r0 = rx_words.size();
        send(8'hA5, 6'd8);
        send(8'h33, 6'd8);
        repeat (3) next();
        rst = 1'b1;
        next();
        rst = 1'b0;
        chk("t5_tx_after_rst", tx, 1'b1);
        chk("t5_ready_after_rst", tx_ready, 1'b1);
        b0 = busy_cnt;
        repeat (30) next();
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_no_frames", busy_cnt - b0, 0);
        chk("t5_no_rx", rx_words.size() - r0, 0);
        $display("t5 reset mid-frame: done=%0d busy after=%0d", done_cnt - d0, busy_cnt - b0);

`ifdef UART_TX_PARITY_EN
        // 6: even parity over 8'h07 is 1
        idx = line_log.size(); b0 = busy_cnt;
        send(8'h07, 6'd8);
        repeat (14) next();
        chk("t6_line", pack(idx, 12), 32'b101110000011);
        chk("t6_frame_cycles", busy_cnt - b0, 11);
        chk("t6_rx_word", rx_at(0), 8'h07);
        $display("t6 word 07 with parity: rx=%0h busy cycles=%0d", rx_at(0), busy_cnt - b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
